// File: rtl/fugue_round_ctrl.sv
// Fugue-256 round controller: holds the 30-word state, absorbs one 32-bit word
// per pass (TIX, then two ROR3/CMIX/SMIX sub-rounds) with SMIX computed externally.
module fugue_round_ctrl #(
  parameter int SMIX_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          in_valid,
  input  logic [31:0]   in_word,
  output logic          in_ready,
  output logic [31:0]   smix_s0,
  output logic [31:0]   smix_s1,
  output logic [31:0]   smix_s2,
  output logic [31:0]   smix_s3,
  input  logic [127:0]  smix_out,
  output logic [959:0]  state_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, ROR, SMX0, SMX1, WB} state_t;

  localparam logic [29:0][31:0] IV = {
    32'h34f8c248, 32'h9149e899, 32'hfbf929de, 32'hf96c621d,
    32'hd2b0b594, 32'he0d4f668, 32'h6671135f, 32'he952bdde,
    {22{32'h0}}
  };

  // SMX0 is the first fill cycle; SMX1 covers the remaining SMIX_LAT-1 cycles.
  localparam logic [7:0] FILL_LAST = 8'(SMIX_LAT - 2);

  state_t             state, state_nxt;
  logic               sub, sub_nxt;
  logic               done_nxt;
  logic [7:0]         fill_cnt, fill_nxt;
  logic [29:0][31:0]  s, s_nxt, rot;

  // T[i] = S[(i+27) mod 30]: a rotation of the word array by three positions.
  assign rot = {s[26:0], s[29:27]};

  assign state_out = s;
  assign smix_s0   = s[0];
  assign smix_s1   = s[1];
  assign smix_s2   = s[2];
  assign smix_s3   = s[3];
  assign in_ready  = (state == IDLE) & ~init;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sub      <= 1'b0;
      done     <= 1'b0;
      fill_cnt <= '0;
      s        <= IV;
    end else begin
      state    <= state_nxt;
      sub      <= sub_nxt;
      done     <= done_nxt;
      fill_cnt <= fill_nxt;
      s        <= s_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sub_nxt   = sub;
    done_nxt  = 1'b0;
    fill_nxt  = fill_cnt;
    s_nxt     = s;
    case (state)
      IDLE: begin
        if (init) begin
          s_nxt = IV;
        end else if (in_valid) begin
          // TIX, every term taken from the pre-edge state
          s_nxt[10] = s[10] ^ s[0];
          s_nxt[0]  = in_word;
          s_nxt[8]  = s[8] ^ in_word;
          s_nxt[1]  = s[1] ^ s[24];
          sub_nxt   = 1'b0;
          state_nxt = ROR;
        end
      end
      ROR: begin
        s_nxt     = rot;
        s_nxt[0]  = rot[0]  ^ rot[4];
        s_nxt[1]  = rot[1]  ^ rot[5];
        s_nxt[2]  = rot[2]  ^ rot[6];
        s_nxt[15] = rot[15] ^ rot[4];
        s_nxt[16] = rot[16] ^ rot[5];
        s_nxt[17] = rot[17] ^ rot[6];
        state_nxt = SMX0;
      end
      SMX0: begin
        fill_nxt  = '0;
        state_nxt = SMX1;
      end
      SMX1: begin
        if (fill_cnt == FILL_LAST) state_nxt = WB;
        else                       fill_nxt  = fill_cnt + 8'd1;
      end
      WB: begin
        s_nxt[0] = smix_out[127:96];
        s_nxt[1] = smix_out[95:64];
        s_nxt[2] = smix_out[63:32];
        s_nxt[3] = smix_out[31:0];
        if (!sub) begin
          sub_nxt   = 1'b1;
          state_nxt = ROR;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fugue_round_ctrl.sv
// Bench for fugue_round_ctrl: free-running 2-stage SMIX stub, software state
// model and a scoreboard of expected final states popped on each done pulse.
module tb_fugue_round_ctrl;

  logic          clk = 1'b0;
  logic          reset, init, in_valid;
  logic [31:0]   in_word;
  logic          in_ready, busy, done;
  logic [31:0]   smix_s0, smix_s1, smix_s2, smix_s3;
  logic [127:0]  smix_out;
  logic [959:0]  state_out;

  fugue_round_ctrl #(.SMIX_LAT(2)) dut (
    .clk(clk), .reset(reset), .init(init), .in_valid(in_valid), .in_word(in_word),
    .in_ready(in_ready), .smix_s0(smix_s0), .smix_s1(smix_s1), .smix_s2(smix_s2),
    .smix_s3(smix_s3), .smix_out(smix_out), .state_out(state_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit mix_mode = 1'b0;
  logic [959:0] model;
  logic [959:0] sb[$];

  // mode 0: identity; mode 1: a nonlinear mixing function standing in for SMIX
  function automatic logic [127:0] smix_f(input bit mode, input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3, m0, m1, m2, m3;
    {x0, x1, x2, x3} = x;
    if (!mode) return x;
    m0 = x0 ^ {x1[23:0], x1[31:24]} ^ (x2 & ~x3);
    m1 = x1 + x2;
    m2 = x2 ^ {x3[15:0], x3[31:16]} ^ 32'h9e3779b9;
    m3 = x3 ^ x0 ^ m1;
    return {m0, m1, m2, m3};
  endfunction

  logic [127:0] p1, p2;
  always @(posedge clk) begin
    p1 <= smix_f(mix_mode, {smix_s0, smix_s1, smix_s2, smix_s3});
    p2 <= p1;
  end
  assign smix_out = p2;

  function automatic logic [31:0] wd(input logic [959:0] st, input int i);
    return st[32*i +: 32];
  endfunction

  function automatic logic [959:0] setw(input logic [959:0] st, input int i, input logic [31:0] v);
    logic [959:0] r;
    r = st;
    r[32*i +: 32] = v;
    return r;
  endfunction

  function automatic logic [959:0] iv();
    logic [959:0] r;
    r = '0;
    r = setw(r, 22, 32'he952bdde); r = setw(r, 23, 32'h6671135f);
    r = setw(r, 24, 32'he0d4f668); r = setw(r, 25, 32'hd2b0b594);
    r = setw(r, 26, 32'hf96c621d); r = setw(r, 27, 32'hfbf929de);
    r = setw(r, 28, 32'h9149e899); r = setw(r, 29, 32'h34f8c248);
    return r;
  endfunction

  function automatic logic [959:0] tix(input logic [959:0] st, input logic [31:0] w);
    logic [959:0] r;
    r = st;
    r = setw(r, 10, wd(st, 10) ^ wd(st, 0));
    r = setw(r, 0, w);
    r = setw(r, 8, wd(st, 8) ^ w);
    r = setw(r, 1, wd(st, 1) ^ wd(st, 24));
    return r;
  endfunction

  function automatic logic [959:0] sub_round(input logic [959:0] st, input bit mode);
    logic [31:0] t[30];
    logic [959:0] r;
    logic [127:0] y;
    for (int i = 0; i < 30; i++) t[i] = wd(st, (i + 27) % 30);
    r = '0;
    for (int i = 0; i < 30; i++) r = setw(r, i, t[i]);
    r = setw(r, 0, t[0] ^ t[4]);   r = setw(r, 1, t[1] ^ t[5]);   r = setw(r, 2, t[2] ^ t[6]);
    r = setw(r, 15, t[15] ^ t[4]); r = setw(r, 16, t[16] ^ t[5]); r = setw(r, 17, t[17] ^ t[6]);
    y = smix_f(mode, {wd(r, 0), wd(r, 1), wd(r, 2), wd(r, 3)});
    r = setw(r, 0, y[127:96]); r = setw(r, 1, y[95:64]);
    r = setw(r, 2, y[63:32]);  r = setw(r, 3, y[31:0]);
    return r;
  endfunction

  function automatic logic [959:0] absorb(input logic [959:0] st, input logic [31:0] w, input bit mode);
    return sub_round(sub_round(tix(st, w), mode), mode);
  endfunction

  task automatic do_reset();
    reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_word = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model = iv();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (wd(state_out, 22) !== 32'he952bdde) begin errors++; $display("FAIL reset_w22: got %h exp e952bdde", wd(state_out, 22)); end
    vectors++; if (wd(state_out, 29) !== 32'h34f8c248) begin errors++; $display("FAIL reset_w29: got %h exp 34f8c248", wd(state_out, 29)); end
    vectors++; if (wd(state_out, 0) !== 32'h0) begin errors++; $display("FAIL reset_w0: got %h exp 0", wd(state_out, 0)); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
  endtask

  task automatic test_single_word();
    logic [959:0] e;
    int k;
    mix_mode = 1'b0;
    in_valid = 1'b1; in_word = 32'h01234567;
    e = absorb(model, 32'h01234567, 1'b0); sb.push_back(e); model = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (wd(state_out, 0) !== 32'h01234567) begin errors++; $display("FAIL tix_s0: got %h exp 01234567", wd(state_out, 0)); end
    vectors++; if (wd(state_out, 8) !== 32'h01234567) begin errors++; $display("FAIL tix_s8: got %h exp 01234567", wd(state_out, 8)); end
    vectors++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL accept_busy: got busy=%b rdy=%b exp 1/0", busy, in_ready); end
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    vectors++; if (k != 9) begin errors++; $display("FAIL done_latency: got %0d exp 9", k); end
    if (done) begin
      e = sb.pop_front();
      vectors++; if (state_out !== e) begin errors++; $display("FAIL single_state: got %h exp %h", state_out, e); end
    end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b exp 0", done); end
  endtask

  task automatic test_init();
    logic [959:0] e;
    int k;
    mix_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_word = 32'hcafef00d;
    e = absorb(model, 32'hcafef00d, 1'b0); sb.push_back(e); model = e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      init = (k == 3);
      if (done) break;
    end
    init = 1'b0;
    vectors++; if (k != 9) begin errors++; $display("FAIL init_busy_latency: got %0d exp 9", k); end
    if (done) begin
      e = sb.pop_front();
      vectors++; if (state_out !== e) begin errors++; $display("FAIL init_busy_state: got %h exp %h", state_out, e); end
    end
    @(negedge clk);
    init = 1'b1; in_valid = 1'b1; in_word = 32'h55aa55aa;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL init_in_ready: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    init = 1'b0; in_valid = 1'b0;
    model = iv();
    vectors++; if (state_out !== iv()) begin errors++; $display("FAIL init_iv: got %h exp %h", state_out, iv()); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL init_no_accept: got busy=%b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int dn;
    mix_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_word = 32'h13579bdf;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    vectors++; if (state_out !== iv()) begin errors++; $display("FAIL rst_mid_iv: got %h exp %h", state_out, iv()); end
    @(negedge clk);
    reset = 1'b0;
    model = iv();
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dn++;
    end
    vectors++; if (dn != 0) begin errors++; $display("FAIL rst_mid_done: got %0d pulses exp 0", dn); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3];
    int acc[3];
    int n_acc, n_done;
    logic [959:0] e;
    words[0] = 32'hdeadbeef; words[1] = 32'h00000001; words[2] = 32'hffffffff;
    mix_mode = 1'b1; n_acc = 0; n_done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_word = words[0];
    for (int cyc = 0; cyc < 60 && n_done < 3; cyc++) begin
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          vectors++; errors++; $display("FAIL b2b_sb_empty: got done exp none");
        end else begin
          e = sb.pop_front();
          vectors++; if (state_out !== e) begin errors++; $display("FAIL b2b_state%0d: got %h exp %h", n_done, state_out, e); end
        end
      end
      if (in_ready && in_valid && n_acc < 3) begin
        acc[n_acc] = cyc;
        e = absorb(model, words[n_acc], 1'b1); sb.push_back(e); model = e;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 3) in_valid = 1'b0;
      else            in_word  = words[n_acc];
      @(negedge clk);
    end
    in_valid = 1'b0;
    vectors++; if (n_done != 3 || n_acc != 3) begin errors++; $display("FAIL b2b_count: got acc=%0d done=%0d exp 3/3", n_acc, n_done); end
    if (n_acc == 3) begin
      vectors++; if (acc[1] - acc[0] != 9) begin errors++; $display("FAIL b2b_gap1: got %0d exp 9", acc[1] - acc[0]); end
      vectors++; if (acc[2] - acc[1] != 9) begin errors++; $display("FAIL b2b_gap2: got %0d exp 9", acc[2] - acc[1]); end
    end
  endtask

  task automatic test_abc();
    logic [31:0] words[3];
    logic [959:0] e;
    int k;
    words[0] = 32'h61626300; words[1] = 32'h00000000; words[2] = 32'h00000018;
    do_reset();
    mix_mode = 1'b1;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1; in_word = words[w];
      e = absorb(model, words[w], 1'b1); sb.push_back(e); model = e;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (done) break;
      end
      if (!done) begin
        vectors++; errors++; $display("FAIL abc_timeout%0d: got no done exp done by 9", w);
      end else begin
        e = sb.pop_front();
        vectors++; if (state_out !== e) begin errors++; $display("FAIL abc_state%0d: got %h exp %h", w, state_out, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_init();
    test_reset_mid();
    test_back_to_back();
    test_abc();
    vectors++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d exp 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
